// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer
//
// This block sequences one floating-point operation at a time through an
// external datapath. It accepts a request, latches the operands and pulses
// start. It then waits for a done pulse or a timeout. After that it holds a
// response until the consumer accepts it.
//
// Ports:
//   clk_in            clock, all state changes on its rising edge
//   rst_in            asynchronous active-high reset
//   req_valid_in      request offered
//   req_ready_out     high only in IDLE; request taken with req_valid_in
//   op_a_in, op_b_in  request operands
//   a_out, b_out      operands latched at acceptance, held until next acceptance
//   start_out         one-cycle start pulse (START state)
//   done_in           one-cycle completion pulse from the datapath
//   result_in         datapath result, valid with done_in
//   rsp_valid_out     response available (RESP state)
//   rsp_ready_in      response consumer ready
//   rsp_data_out      captured result, or 0 on timeout
//   rsp_timeout_out   response is an abort (no done_in arrived)
//   busy_out          high in every state except IDLE
//   stray_done_out    sticky: done_in seen outside WAIT, cleared only by reset

module fp_op_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 40   // legal range 2..255
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [DATA_W-1:0] op_a_in,
    input  logic [DATA_W-1:0] op_b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              start_out,
    input  logic              done_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              rsp_valid_out,
    input  logic              rsp_ready_in,
    output logic [DATA_W-1:0] rsp_data_out,
    output logic              rsp_timeout_out,
    output logic              busy_out,
    output logic              stray_done_out
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StResp
    } state_e;

    // Value the wait counter holds in the last permitted WAIT cycle.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              stray_q, stray_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_q       <= stray_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        // The FSM ignores a done pulse outside WAIT, but the pulse is remembered.
        stray_d       = stray_q | (done_in && (state_q != StWait));

        case (state_q)
            StIdle: begin
                if (req_valid_in) begin
                    a_d     = op_a_in;
                    b_d     = op_b_in;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // done_in takes priority over a timeout in the same cycle.
                if (done_in) begin
                    rsp_data_d    = result_in;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready_out   = (state_q == StIdle);
    assign start_out       = (state_q == StStart);
    assign rsp_valid_out   = (state_q == StResp);
    assign busy_out        = (state_q != StIdle);
    assign a_out           = a_q;
    assign b_out           = b_q;
    assign rsp_data_out    = rsp_data_q;
    assign rsp_timeout_out = rsp_timeout_q;
    assign stray_done_out  = stray_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed testbench for fp_op_sequencer (DATA_W=32, TIMEOUT=40).
// Inputs change 1 time unit after a rising edge. Outputs are also sampled
// there, and all outputs are registered state.

module tb_fp_op_sequencer;

    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 40;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req_valid_in;
    logic          req_ready_out;
    logic [DW-1:0] op_a_in;
    logic [DW-1:0] op_b_in;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          start_out;
    logic          done_in;
    logic [DW-1:0] result_in;
    logic          rsp_valid_out;
    logic          rsp_ready_in;
    logic [DW-1:0] rsp_data_out;
    logic          rsp_timeout_out;
    logic          busy_out;
    logic          stray_done_out;

    int tests = 0;
    int fails = 0;
    int waits;

    fp_op_sequencer #(
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .op_a_in         (op_a_in),
        .op_b_in         (op_b_in),
        .a_out           (a_out),
        .b_out           (b_out),
        .start_out       (start_out),
        .done_in         (done_in),
        .result_in       (result_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_ready_in    (rsp_ready_in),
        .rsp_data_out    (rsp_data_out),
        .rsp_timeout_out (rsp_timeout_out),
        .busy_out        (busy_out),
        .stray_done_out  (stray_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_out), 32'd1);
        chk({tag, "_start"}, 32'(start_out), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_out), 32'd0);
        chk({tag, "_timeout"}, 32'(rsp_timeout_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_stray"}, 32'(stray_done_out), 32'd0);
        chk({tag, "_a"}, a_out, 32'd0);
        chk({tag, "_b"}, b_out, 32'd0);
        chk({tag, "_data"}, rsp_data_out, 32'd0);
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid_in = 1'b0;
        op_a_in      = '0;
        op_b_in      = '0;
        done_in      = 1'b0;
        result_in    = '0;
        rsp_ready_in = 1'b0;
        step();
        step();
        check_reset("reset");
        rst_in = 1'b0;
        step();
        chk("idle_ready", 32'(req_ready_out), 32'd1);

        // Normal op: done 33 cycles after the start pulse.
        op_a_in      = 32'h3F80_0000;
        op_b_in      = 32'h4000_0000;
        req_valid_in = 1'b1;
        step();
        req_valid_in = 1'b0;
        op_a_in      = '0;
        op_b_in      = '0;
        chk("t1_start", 32'(start_out), 32'd1);
        chk("t1_a", a_out, 32'h3F80_0000);
        chk("t1_b", b_out, 32'h4000_0000);
        chk("t1_ready_low", 32'(req_ready_out), 32'd0);
        chk("t1_busy", 32'(busy_out), 32'd1);
        for (int i = 1; i <= 33; i++) begin
            step();
            chk("t1_wait_nostart", 32'(start_out), 32'd0);
            chk("t1_wait_norsp", 32'(rsp_valid_out), 32'd0);
        end
        done_in   = 1'b1;
        result_in = 32'h4040_0000;
        step();
        done_in   = 1'b0;
        result_in = 32'hDEAD_BEEF;
        chk("t1_rsp_valid", 32'(rsp_valid_out), 32'd1);
        chk("t1_rsp_data", rsp_data_out, 32'h4040_0000);
        chk("t1_rsp_timeout", 32'(rsp_timeout_out), 32'd0);
        rsp_ready_in = 1'b1;
        step();
        rsp_ready_in = 1'b0;
        chk("t1_back_idle", 32'(req_ready_out), 32'd1);
        chk("t1_rsp_drop", 32'(rsp_valid_out), 32'd0);
        chk("t1_not_busy", 32'(busy_out), 32'd0);

        // Timeout: no done, expect exactly TIMEOUT cycles in WAIT.
        op_a_in      = 32'h0000_0001;
        op_b_in      = 32'h0000_0002;
        req_valid_in = 1'b1;
        step();
        req_valid_in = 1'b0;
        chk("t2_start", 32'(start_out), 32'd1);
        waits = 0;
        step();
        while (rsp_valid_out !== 1'b1 && waits < 200) begin
            waits++;
            step();
        end
        chk("t2_wait_cycles", 32'(waits), 32'(TMO));
        chk("t2_rsp_valid", 32'(rsp_valid_out), 32'd1);
        chk("t2_rsp_data", rsp_data_out, 32'd0);
        chk("t2_rsp_timeout", 32'(rsp_timeout_out), 32'd1);
        rsp_ready_in = 1'b1;
        step();
        rsp_ready_in = 1'b0;
        chk("t2_back_idle", 32'(req_ready_out), 32'd1);

        // done_in on the last WAIT cycle before timeout wins.
        op_a_in      = 32'h1111_1111;
        op_b_in      = 32'h2222_2222;
        req_valid_in = 1'b1;
        step();
        req_valid_in = 1'b0;
        chk("t3_start", 32'(start_out), 32'd1);
        for (int i = 1; i <= int'(TMO); i++) begin
            step();
        end
        chk("t3_last_wait_norsp", 32'(rsp_valid_out), 32'd0);
        chk("t3_last_wait_busy", 32'(busy_out), 32'd1);
        done_in   = 1'b1;
        result_in = 32'h1234_5678;
        step();
        done_in   = 1'b0;
        result_in = '0;
        chk("t3_rsp_valid", 32'(rsp_valid_out), 32'd1);
        chk("t3_rsp_data", rsp_data_out, 32'h1234_5678);
        chk("t3_rsp_timeout", 32'(rsp_timeout_out), 32'd0);

        // Back-pressure in RESP while a second request waits.
        op_a_in      = 32'hAAAA_5555;
        op_b_in      = 32'h5555_AAAA;
        req_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold_valid", 32'(rsp_valid_out), 32'd1);
            chk("t4_hold_data", rsp_data_out, 32'h1234_5678);
            chk("t4_hold_timeout", 32'(rsp_timeout_out), 32'd0);
            chk("t4_hold_ready_low", 32'(req_ready_out), 32'd0);
            chk("t4_hold_a", a_out, 32'h1111_1111);
        end
        rsp_ready_in = 1'b1;
        step();
        rsp_ready_in = 1'b0;
        chk("t4_idle_ready", 32'(req_ready_out), 32'd1);
        chk("t4_idle_norsp", 32'(rsp_valid_out), 32'd0);
        chk("t4_idle_a_old", a_out, 32'h1111_1111);
        step();
        req_valid_in = 1'b0;
        chk("t4_second_start", 32'(start_out), 32'd1);
        chk("t4_second_a", a_out, 32'hAAAA_5555);
        chk("t4_second_b", b_out, 32'h5555_AAAA);
        step();
        done_in   = 1'b1;
        result_in = 32'h0BAD_F00D;
        step();
        done_in   = 1'b0;
        chk("t4_second_data", rsp_data_out, 32'h0BAD_F00D);
        rsp_ready_in = 1'b1;
        step();
        rsp_ready_in = 1'b0;
        chk("t4_no_stray", 32'(stray_done_out), 32'd0);

        // Stray done in IDLE.
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk("t5_stray_set", 32'(stray_done_out), 32'd1);
        chk("t5_still_idle", 32'(req_ready_out), 32'd1);
        chk("t5_not_busy", 32'(busy_out), 32'd0);
        chk("t5_no_start", 32'(start_out), 32'd0);
        step();
        chk("t5_stray_sticky", 32'(stray_done_out), 32'd1);

        // Asynchronous reset mid-WAIT, then a late done.
        op_a_in      = 32'h7777_7777;
        op_b_in      = 32'h8888_8888;
        req_valid_in = 1'b1;
        step();
        req_valid_in = 1'b0;
        step();
        step();
        chk("t6_in_wait", 32'(busy_out), 32'd1);
        #1;
        rst_in = 1'b1;
        #1;
        check_reset("t6_async_reset");
        rst_in    = 1'b0;
        done_in   = 1'b1;
        result_in = 32'hCAFE_CAFE;
        step();
        done_in = 1'b0;
        chk("t6_late_stray", 32'(stray_done_out), 32'd1);
        chk("t6_no_rsp", 32'(rsp_valid_out), 32'd0);
        chk("t6_idle", 32'(busy_out), 32'd0);
        chk("t6_data_zero", rsp_data_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_op_sequencer.md
FP_OP_SEQUENCER -- requirements
Module: fp_op_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 40, giving the maximum cycles spent in WAIT before abort; legal range 2..255.
REQ-003 The block SHALL use exactly one clock and an asynchronous, active-high reset, with ports as follows:
 clk_in  input  1  clock; all state changes on its rising edge.
 rst_in  input  1  asynchronous, active-high reset.
 req_valid_in  input  1  request offered.
 req_ready_out  output  1  request accepted when high together with req_valid_in.
 op_a_in  input  DATA_W  operand A of the request.
 op_b_in  input  DATA_W  operand B of the request.
 a_out  output  DATA_W  latched operand A to the datapath.
 b_out  output  DATA_W  latched operand B to the datapath.
 start_out  output  1  single-cycle start pulse to the datapath and its done-delay module.
 done_in  input  1  single-cycle completion pulse from the done-delay module.
 result_in  input  DATA_W  datapath result; valid in the cycle done_in is high.
 rsp_valid_out  output  1  response available.
 rsp_ready_in  input  1  response consumer ready.
 rsp_data_out  output  DATA_W  captured result.
 rsp_timeout_out  output  1  response is an abort; no done_in arrived.
 busy_out  output  1  high in every state except IDLE.
 stray_done_out  output  1  sticky flag: done_in seen outside WAIT.

Function
REQ-004 FSM states SHALL be IDLE, START, WAIT, RESP; one state per cycle minimum.
REQ-005 req_ready_out SHALL equal 1 only in IDLE.
REQ-006 In IDLE, when req_valid_in=1 the block SHALL latch op_a_in/op_b_in into a_out/b_out and move to START.
REQ-007 a_out/b_out SHALL hold their value from acceptance until the next acceptance.
REQ-008 In START, start_out SHALL be 1 for exactly that one cycle, the wait counter SHALL clear to 0, and the next state SHALL be WAIT.
REQ-009 start_out SHALL be 0 in every other state.
REQ-010 In WAIT, the counter SHALL increment by 1 per cycle; the counter is 8 bits and SHALL never wrap.
REQ-011 In WAIT, done_in=1 SHALL capture result_in into rsp_data_out, clear rsp_timeout_out, and move to RESP.
REQ-012 In WAIT with done_in=0 and counter equal to TIMEOUT-1, the block SHALL set rsp_data_out=0 and rsp_timeout_out=1, then move to RESP.
REQ-013 If done_in and the timeout condition coincide, done_in SHALL win.
REQ-014 In RESP, rsp_valid_out SHALL be 1, and rsp_data_out/rsp_timeout_out SHALL stay stable until rsp_ready_in=1.
REQ-015 rsp_valid_out=1 with rsp_ready_in=1 SHALL complete the handshake and move to IDLE; rsp_valid_out is 0 in all other states.
REQ-016 Latency: the rising edge sampling done_in=1 in WAIT SHALL be followed by rsp_valid_out=1 in the next cycle.
REQ-017 A done_in pulse in IDLE, START or RESP SHALL be ignored by the FSM and SHALL set stray_done_out=1, which remains set until reset.
REQ-018 A new request SHALL NOT be accepted before the previous response handshake completes; after the handshake, IDLE lasts at least one cycle.

Reset
REQ-019 Asserting rst_in at any time, including mid-WAIT, SHALL force IDLE immediately; the outstanding operation is discarded without a response.
REQ-020 Reset values SHALL be: counter=0; a_out=0; b_out=0; rsp_data_out=0; start_out=0; rsp_valid_out=0; rsp_timeout_out=0; busy_out=0; stray_done_out=0; req_ready_out=1.

Verification
REQ-021 Request A=0x3F800000, B=0x40000000; done_in 33 cycles after start_out with result_in=0x40400000 -> one start_out pulse; rsp_valid_out the next cycle with data 0x40400000 and timeout=0.
REQ-022 Request with done_in never asserted, TIMEOUT=40 -> rsp_valid_out 40 cycles after START with data 0 and timeout=1.
REQ-023 done_in on the final timeout cycle -> normal response with timeout=0.
REQ-024 rsp_ready_in held 0 for 10 cycles in RESP, with a second req_valid_in presented -> response stable, req_ready_out=0; second request accepted only after the handshake.
REQ-025 done_in pulsed in IDLE -> no state change, stray_done_out=1; rst_in pulsed mid-WAIT -> all outputs at reset values and the late done_in sets stray_done_out.
